// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready handshakes on both sides.
// Status flags come straight from the registered occupancy count.
module sync_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_write_tvalid,
  output logic                  fifo_write_tready,
  input  logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_read_tready,
  output logic                  fifo_read_tvalid,
  output logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_almost_full,
  output logic                  fifo_empty,
  output logic                  fifo_full
);

  localparam int COUNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0]  LAST_PTR    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT  = COUNT_WIDTH'(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] AFULL_COUNT = COUNT_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr;
  logic [ADDR_WIDTH-1:0]  rd_ptr;
  logic [COUNT_WIDTH-1:0] count;
  logic                   write_en;
  logic                   read_en;

  assign fifo_empty        = (count == '0);
  assign fifo_full         = (count == FULL_COUNT);
  assign fifo_almost_full  = (count >= AFULL_COUNT);
  assign fifo_write_tready = !fifo_full;
  assign fifo_read_tvalid  = !fifo_empty;
  assign fifo_rdata        = mem[rd_ptr];

  assign write_en = fifo_write_tvalid && fifo_write_tready;
  assign read_en  = fifo_read_tready && fifo_read_tvalid;

  // Storage is deliberately left unreset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_ptr] <= fifo_wdata;
    end
  end

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write_en) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (read_en) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      if (write_en && !read_en) begin
        count <= count + 1'b1;
      end else if (read_en && !write_en) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a vector table for basic traffic, then
// hand-written sequences for full, wrap and mid-stream reset corners.
module tb_sync_fifo;

  logic         clk = 1'b0;
  logic         reset;
  logic         fifo_write_tvalid;
  logic         fifo_write_tready;
  logic [127:0] fifo_wdata;
  logic         fifo_read_tready;
  logic         fifo_read_tvalid;
  logic [127:0] fifo_rdata;
  logic         fifo_almost_full;
  logic         fifo_empty;
  logic         fifo_full;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         wv;
    logic [127:0] wd;
    logic         rr;
    logic         e_tvalid;
    logic [127:0] e_rdata;
    logic         e_empty;
    logic         e_full;
    logic         e_afull;
    logic         e_wready;
  } vec_t;

  vec_t vecs [9];

  sync_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(128), .DEPTH(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .fifo_write_tvalid (fifo_write_tvalid),
    .fifo_write_tready (fifo_write_tready),
    .fifo_wdata        (fifo_wdata),
    .fifo_read_tready  (fifo_read_tready),
    .fifo_read_tvalid  (fifo_read_tvalid),
    .fifo_rdata        (fifo_rdata),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_empty        (fifo_empty),
    .fifo_full         (fifo_full)
  );

  always #5 clk = ~clk;

  task automatic checkOne(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outputs depend only on registered state, so they are checked just after an edge.
  task automatic checkOutput(input string name, input logic e_tv, input logic [127:0] e_rd,
                             input logic e_em, input logic e_fu, input logic e_af,
                             input logic e_wr);
    checkOne({name, ".tvalid"}, 128'(fifo_read_tvalid), 128'(e_tv));
    checkOne({name, ".empty"}, 128'(fifo_empty), 128'(e_em));
    checkOne({name, ".full"}, 128'(fifo_full), 128'(e_fu));
    checkOne({name, ".afull"}, 128'(fifo_almost_full), 128'(e_af));
    checkOne({name, ".wready"}, 128'(fifo_write_tready), 128'(e_wr));
    if (e_tv) checkOne({name, ".rdata"}, fifo_rdata, e_rd);
  endtask

  task automatic applyStimulus(input logic wv, input logic [127:0] wd, input logic rr);
    fifo_write_tvalid = wv;
    fifo_wdata        = wd;
    fifo_read_tready  = rr;
    @(posedge clk);
    #1;
    fifo_write_tvalid = 1'b0;
    fifo_read_tready  = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic fillSeq(input int n, input logic [127:0] base);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, base + 128'(i), 1'b0);
  endtask

  initial begin
    reset             = 1'b1;
    fifo_write_tvalid = 1'b0;
    fifo_wdata        = '0;
    fifo_read_tready  = 1'b0;

    vecs[0] = '{1'b1, 128'h1,  1'b0, 1'b0, 128'h0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 128'h2,  1'b0, 1'b1, 128'h1,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 128'h3,  1'b0, 1'b1, 128'h1,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 128'h0,  1'b1, 1'b1, 128'h1,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 128'h0,  1'b1, 1'b1, 128'h2,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 128'h0,  1'b1, 1'b1, 128'h3,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 128'h77, 1'b1, 1'b0, 128'h0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 128'h0,  1'b1, 1'b1, 128'h77, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 128'h0,  1'b0, 1'b0, 128'h0,  1'b1, 1'b0, 1'b0, 1'b1};

    // Reset then idle
    doReset();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("reset", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Table: three writes, in-order drain, read on empty with concurrent write
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("vec%0d", i), vecs[i].e_tvalid, vecs[i].e_rdata, vecs[i].e_empty,
                  vecs[i].e_full, vecs[i].e_afull, vecs[i].e_wready);
      applyStimulus(vecs[i].wv, vecs[i].wd, vecs[i].rr);
    end

    // Fill to full, blocked extra write, exact drain
    doReset();
    fillSeq(15, 128'h0);
    checkOutput("fill15", 1'b1, 128'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 128'hF, 1'b0);
    checkOutput("fill16", 1'b1, 128'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 128'hBAD, 1'b0);
    checkOutput("blocked", 1'b1, 128'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checkOne($sformatf("drain3_%0d", i), fifo_rdata, 128'(i));
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("drained3", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Full with simultaneous read and write: only the read happens
    fillSeq(16, 128'h0);
    applyStimulus(1'b1, 128'h100, 1'b1);
    checkOutput("fullrw", 1'b1, 128'h1, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 128'h100, 1'b0);
    checkOutput("refill", 1'b1, 128'h1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checkOne($sformatf("drain4_%0d", i), fifo_rdata, (i == 15) ? 128'h100 : 128'(i + 1));
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("drained4", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Half-full streaming: pointers wrap while occupancy stays at 8
    doReset();
    fillSeq(8, 128'h200);
    for (int k = 0; k < 40; k++) begin
      checkOutput($sformatf("stream%0d", k), 1'b1,
                  (k < 8) ? 128'h200 + 128'(k) : 128'h300 + 128'(k - 8),
                  1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 128'h300 + 128'(k), 1'b1);
    end
    for (int k = 0; k < 8; k++) begin
      checkOne($sformatf("tail%0d", k), fifo_rdata, 128'h300 + 128'(32 + k));
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("drained5", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-stream wins over a concurrent write
    fillSeq(5, 128'h400);
    checkOutput("pre_reset", 1'b1, 128'h400, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    applyStimulus(1'b1, 128'h499, 1'b1);
    reset = 1'b0;
    checkOutput("mid_reset", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 128'hA5, 1'b0);
    checkOutput("after_reset", 1'b1, 128'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("final", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
